ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage that sits directly downstream of the ID/EX pipeline register and consumes its operand, instruction and control outputs.
- Contains the 8-bit ALU, the architectural carry (C) and zero (Z) flag registers, conditional-execution squash logic and the EX/MEM pipeline register.
- The EX/MEM register supports stall (hold) and flush (bubble) and feeds the memory stage.

Parameters:
- DW, 8, datapath width; ALU, operand and result width.
- IW, 19, instruction width carried down the pipe.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- ID_EX_A  in  DW  operand A.
- ID_EX_B  in  DW  operand B / store data.
- ID_EX_instruction  in  IW  fields: rd=[13:11], rs=[10:8], rt=[7:5], imm=[7:0].
- ID_EX_mem_write, ID_EX_reg_write  in  1  write enables from decode.
- ID_EX_alu_use_carry  in  1  carry-in = C flag when 1; otherwise 0 (add) or 1 (sub).
- ID_EX_alu_B_mux  in  1  0: B operand = ID_EX_B; 1: B operand = imm.
- ID_EX_select_c, ID_EX_select_z  in  1  conditional-execution predicates.
- ID_EX_write_c, ID_EX_write_z  in  1  flag update enables.
- ID_EX_alu_op  in  3  ALU operation.
- ID_EX_reg_write_mux  in  2  writeback source, passed through unchanged.
- stall  in  1  hold EX/MEM register and flags.
- flush  in  1  kill the instruction currently in EX.
- EX_MEM_alu_result  out  DW  registered ALU result.
- EX_MEM_B  out  DW  registered store data (forwarded B, never imm).
- EX_MEM_instruction  out  IW  registered instruction.
- EX_MEM_mem_write, EX_MEM_reg_write  out  1  registered enables, after squash.
- EX_MEM_reg_write_mux  out  2  registered writeback select.
- flag_c, flag_z  out  1  current C and Z flag register values.

Behaviour:
- Reset:
  - All outputs and flag registers are 0.
  - Reset is asynchronous; asserting it mid-operation discards the in-flight instruction.
- ALU operations (combinational; 9-bit internal sum, cout = bit 8):
  - 000 add: A+B+cin.
  - 001 sub: A+~B+cin; cout=1 means no borrow.
  - 010 and; 011 or; 100 xor: cout=0.
  - 101 shl by 1: cout=A[7].
  - 110 shr by 1 logical: cout=A[0].
  - 111 pass B: cout=0.
- Z source: Z_new = (result==0) for every op.
- Predicate ok = (!select_c | flag_c) & (!select_z | flag_z), evaluated against the flag values before this instruction's own update.
- Squash: if !ok, the captured mem_write and reg_write are 0 and neither flag is written; the result is still captured.
- Clock edge priority: flush > stall > normal.
  - flush=1: EX/MEM captures a bubble (all fields 0); flags are unchanged. This holds even with stall=1.
  - stall=1, flush=0: all EX/MEM outputs and flags hold their values.
  - Normal: EX/MEM captures the new values. C<=cout if write_c&ok. Z<=Z_new if write_z&ok.
- Latency: exactly 1 cycle from ID/EX inputs to EX_MEM outputs.
- Back-to-back flag dependency needs no bubble: the flag is registered in this stage, and the next instruction sees the updated value in the following cycle.

Optional Feature:
- Macro: EX_FWD_EN.
- When defined, adds ports:
  - wb_reg_write  in  1.
  - wb_rd  in  3.
  - wb_data  in  DW.
- Operand A forwarding:
  - Replaced by EX_MEM_alu_result when EX_MEM_reg_write and EX_MEM rd == rs.
  - Otherwise replaced by wb_data when wb_reg_write and wb_rd == rs.
  - EX/MEM has priority over WB.
- Operand B forwarding: same rules using rt, applied before the imm mux, so store data also receives the forwarded value.
- When not defined: no extra ports; operands are used exactly as received.

Test Plan:
- Reset release, then add with A=0x7F, B=0x01, use_carry=0, write_c=write_z=1 -> next cycle result=0x80, C=0, Z=0.
- add with A=0xFF, B=0x01, write_c=write_z=1 -> result=0x00, C=1, Z=1. Next instruction add with A=0x00, imm=0x00, alu_B_mux=1, use_carry=1 -> result=0x01.
- select_z=1 while Z=0, reg_write=1, mem_write=1 -> EX_MEM_reg_write=0, EX_MEM_mem_write=0, flags unchanged.
- Valid add in EX with stall=1 for 3 cycles -> outputs and flags hold their prior values. Same cycle with stall=1 and flush=1 -> bubble captured (all outputs 0).
- Assert reset low mid-cycle while EX_MEM_reg_write=1, C=1 -> all outputs and flags read 0 before the next clock edge.
- EX_FWD_EN: instruction 1 writes rd=2 with result 0x05; instruction 2 has rs=2 with stale A=0x00, op add, B=0x03 -> result=0x08.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Holds the ALU, the architectural C/Z flags, predicate squash logic and
// the EX/MEM register with stall (hold) and flush (bubble) control.
// Optional operand forwarding from EX/MEM and WB: define EX_FWD_EN.
module ex_stage #(
   parameter int DW = 8,
   parameter int IW = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] ID_EX_A,
   input  logic [DW-1:0] ID_EX_B,
   input  logic [IW-1:0] ID_EX_instruction,
   input  logic          ID_EX_mem_write,
   input  logic          ID_EX_reg_write,
   input  logic          ID_EX_alu_use_carry,
   input  logic          ID_EX_alu_B_mux,
   input  logic          ID_EX_select_c,
   input  logic          ID_EX_select_z,
   input  logic          ID_EX_write_c,
   input  logic          ID_EX_write_z,
   input  logic [2:0]    ID_EX_alu_op,
   input  logic [1:0]    ID_EX_reg_write_mux,
   input  logic          stall,
   input  logic          flush,
`ifdef EX_FWD_EN
   input  logic          wb_reg_write,
   input  logic [2:0]    wb_rd,
   input  logic [DW-1:0] wb_data,
`endif
   output logic [DW-1:0] EX_MEM_alu_result,
   output logic [DW-1:0] EX_MEM_B,
   output logic [IW-1:0] EX_MEM_instruction,
   output logic          EX_MEM_mem_write,
   output logic          EX_MEM_reg_write,
   output logic [1:0]    EX_MEM_reg_write_mux,
   output logic          flag_c,
   output logic          flag_z
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_PASS = 3'b111
   } alu_op_e;

   // Pipeline and flag state
   logic [DW-1:0] r_alu_result;
   logic [DW-1:0] r_b;
   logic [IW-1:0] r_instruction;
   logic          r_mem_write;
   logic          r_reg_write;
   logic [1:0]    r_reg_write_mux;
   logic          r_flag_c;
   logic          r_flag_z;

   // Datapath
   logic [DW-1:0] w_op_a;
   logic [DW-1:0] w_fwd_b;
   logic [DW-1:0] w_op_b;
   logic [DW:0]   w_sum;
   logic [DW-1:0] w_result;
   logic          w_cout;
   logic          w_cin;
   logic          w_z_new;
   logic          w_ok;

`ifdef EX_FWD_EN
   logic [2:0] w_rs;
   logic [2:0] w_rt;
   logic [2:0] w_ex_rd;

   assign w_rs    = ID_EX_instruction[10:8];
   assign w_rt    = ID_EX_instruction[7:5];
   assign w_ex_rd = r_instruction[13:11];

   // Operand forwarding: the younger EX/MEM result wins over WB
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_op_a  = ID_EX_A;
      w_fwd_b = ID_EX_B;
      if (r_reg_write && (w_ex_rd == w_rs))
         w_op_a = r_alu_result;
      else if (wb_reg_write && (wb_rd == w_rs))
         w_op_a = wb_data;
      if (r_reg_write && (w_ex_rd == w_rt))
         w_fwd_b = r_alu_result;
      else if (wb_reg_write && (wb_rd == w_rt))
         w_fwd_b = wb_data;
   end
`else
   assign w_op_a  = ID_EX_A;
   assign w_fwd_b = ID_EX_B;
`endif

   // The imm mux sits after forwarding; store data always takes the register path
   assign w_op_b = ID_EX_alu_B_mux ? ID_EX_instruction[DW-1:0] : w_fwd_b;

   // Carry-in: live C flag when chained, otherwise 1 for subtract (two's complement)
   assign w_cin = ID_EX_alu_use_carry ? r_flag_c : (ID_EX_alu_op == OP_SUB);

   // ALU: result and carry-out for the selected operation
   always_comb begin
      w_sum    = '0;
      w_result = '0;
      w_cout   = 1'b0;
      case (alu_op_e'(ID_EX_alu_op))
         OP_ADD: begin
            w_sum    = {1'b0, w_op_a} + {1'b0, w_op_b} + {{DW{1'b0}}, w_cin};
            w_result = w_sum[DW-1:0];
            w_cout   = w_sum[DW];
         end
         OP_SUB: begin
            w_sum    = {1'b0, w_op_a} + {1'b0, ~w_op_b} + {{DW{1'b0}}, w_cin};
            w_result = w_sum[DW-1:0];
            w_cout   = w_sum[DW];
         end
         OP_AND:  w_result = w_op_a & w_op_b;
         OP_OR:   w_result = w_op_a | w_op_b;
         OP_XOR:  w_result = w_op_a ^ w_op_b;
         OP_SHL: begin
            w_result = {w_op_a[DW-2:0], 1'b0};
            w_cout   = w_op_a[DW-1];
         end
         OP_SHR: begin
            w_result = {1'b0, w_op_a[DW-1:1]};
            w_cout   = w_op_a[0];
         end
         OP_PASS: w_result = w_op_b;
      endcase
   end

   assign w_z_new = (w_result == '0);

   // Predicate uses the flags as they stand before this instruction updates them
   assign w_ok = (!ID_EX_select_c || r_flag_c) && (!ID_EX_select_z || r_flag_z);

   // EX/MEM register and flags: reset > flush > stall > capture
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         r_alu_result    <= '0;
         r_b             <= '0;
         r_instruction   <= '0;
         r_mem_write     <= 1'b0;
         r_reg_write     <= 1'b0;
         r_reg_write_mux <= '0;
         r_flag_c        <= 1'b0;
         r_flag_z        <= 1'b0;
      end else if (flush) begin
         r_alu_result    <= '0;
         r_b             <= '0;
         r_instruction   <= '0;
         r_mem_write     <= 1'b0;
         r_reg_write     <= 1'b0;
         r_reg_write_mux <= '0;
      end else if (!stall) begin
         r_alu_result    <= w_result;
         r_b             <= w_fwd_b;
         r_instruction   <= ID_EX_instruction;
         r_mem_write     <= ID_EX_mem_write && w_ok;
         r_reg_write     <= ID_EX_reg_write && w_ok;
         r_reg_write_mux <= ID_EX_reg_write_mux;
         if (ID_EX_write_c && w_ok)
            r_flag_c <= w_cout;
         if (ID_EX_write_z && w_ok)
            r_flag_z <= w_z_new;
      end
   end

   assign EX_MEM_alu_result    = r_alu_result;
   assign EX_MEM_B             = r_b;
   assign EX_MEM_instruction   = r_instruction;
   assign EX_MEM_mem_write     = r_mem_write;
   assign EX_MEM_reg_write     = r_reg_write;
   assign EX_MEM_reg_write_mux = r_reg_write_mux;
   assign flag_c               = r_flag_c;
   assign flag_z               = r_flag_z;

endmodule
